// File: rtl/mem_bus_adapter.sv
// Bridges controller mem_read/mem_write levels onto a valid/ready memory bus,
// stalling the controller until the single resulting transaction completes.
module mem_bus_adapter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_we,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_be,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_data
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic              mis_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              req_c;
  logic              mis_in_c;
  logic              timeout_c;
  logic [1:0]        lane_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [31:0]       load_ext_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_rep_c;

  assign req_c     = mem_read | mem_write;
  assign timeout_c = (cnt_q == CNT_LAST);
  assign lane_c    = addr_q[1:0];

  // Size 11 is treated as a word access.
  always_comb begin
    mis_in_c = 1'b0;
    case (funct3[1:0])
      2'b00:   mis_in_c = 1'b0;
      2'b01:   mis_in_c = addr[0];
      default: mis_in_c = (addr[1:0] != 2'b00);
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_c) state_d = mis_in_c ? DONE : REQ;
      REQ:  if (bus_req_ready) state_d = WAIT;
      WAIT: if (bus_resp_valid || timeout_c) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Load lane selection and extension from the latched access attributes
  always_comb begin
    byte_c     = bus_resp_data[{lane_c, 3'b000} +: 8];
    half_c     = lane_c[1] ? bus_resp_data[31:16] : bus_resp_data[15:0];
    load_ext_c = bus_resp_data;
    case (funct3_q[1:0])
      2'b00:   load_ext_c = funct3_q[2] ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b01:   load_ext_c = funct3_q[2] ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      default: load_ext_c = bus_resp_data;
    endcase
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be_c        = 4'b1111;
    wdata_rep_c = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be_c        = 4'b0001 << lane_c;
        wdata_rep_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c        = 4'b0011 << lane_c;
        wdata_rep_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c        = 4'b1111;
        wdata_rep_c = wdata_q;
      end
    endcase
  end

  // Transaction latches, timeout counter, pending flags and load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rdata    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_c) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            funct3_q <= funct3;
            we_q     <= mem_write;
            mis_q    <= mis_in_c;
            err_q    <= 1'b0;
            if (mis_in_c && !mem_write) rdata <= '0;
          end
        end
        REQ: begin
          if (bus_req_ready) cnt_q <= '0;
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus_resp_valid) begin
            if (!we_q) rdata <= load_ext_c;
          end else if (timeout_c) begin
            err_q <= 1'b1;
            if (!we_q) rdata <= '0;
          end
        end
        DONE: begin
          mis_q <= 1'b0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Stall is combinational so the controller freezes in its request cycle.
  assign stall = rst_n & (((state_q == IDLE) & req_c) | (state_q == REQ) | (state_q == WAIT));

  assign misalign      = (state_q == DONE) & mis_q;
  assign bus_err       = (state_q == DONE) & err_q;
  assign bus_req_valid = (state_q == REQ);
  assign bus_req_we    = bus_req_valid & we_q;
  assign bus_req_addr  = bus_req_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_req_be    = bus_req_valid ? be_c : 4'h0;
  assign bus_req_wdata = bus_req_valid ? wdata_rep_c : 32'h0;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Scoreboard bench for mem_bus_adapter: a responder model drives the bus, expected
// completions are queued at request time and compared when the adapter finishes.
module tb_mem_bus_adapter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic        stall;
  logic [31:0] rdata;
  logic        misalign, bus_err;
  logic        bus_req_valid, bus_req_ready, bus_req_we;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_be;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_data;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [7:0]  stall_cyc;
    logic [7:0]  valid_cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_rdata = 32'h0;

  mem_bus_adapter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .funct3(funct3), .stall(stall), .rdata(rdata),
    .misalign(misalign), .bus_err(bus_err), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_be(bus_req_be),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; mem_read = 0; mem_write = 0; addr = 0; wdata = 0; funct3 = 0;
    bus_req_ready = 0; bus_resp_valid = 0; bus_resp_data = 0;
    repeat (2) @(negedge clk);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    tests++; if (bus_req_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus_req_valid); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", rdata); end
    tests++; if ({misalign, bus_err} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {misalign, bus_err}); end
    tests++; if ({bus_req_we, bus_req_be, bus_req_addr, bus_req_wdata} !== 69'h0) begin
      fails++; $display("FAIL reset_bus got we=%b be=%h addr=%h wd=%h want 0", bus_req_we, bus_req_be, bus_req_addr, bus_req_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One transaction: builds the expectation, plays the memory, checks at completion.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                         input int rdly, input int rlat, input logic [31:0] rsp,
                         input bit no_resp, input bit keep);
    exp_t        e, got;
    logic [1:0]  o;
    logic [7:0]  b;
    logic [15:0] h;
    int          stall_cnt, nvalid, req_cyc, wait_cyc;
    bit          in_wait, done;
    o = a[1:0];
    e = '0;
    e.we    = wr;
    e.baddr = {a[31:2], 2'b00};
    case (f3[1:0])
      2'b00: begin e.mis = 1'b0; e.be = 4'b0001 << o; e.bwdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; end
      2'b01: begin e.mis = a[0]; e.be = 4'b0011 << o; e.bwdata = {wd[15:0], wd[15:0]}; end
      default: begin e.mis = (o != 2'b00); e.be = 4'b1111; e.bwdata = wd; end
    endcase
    e.err = !e.mis && no_resp;
    if (!wr) begin
      if (e.mis || no_resp) model_rdata = 32'h0;
      else begin
        case (o)
          2'd0: b = rsp[7:0];
          2'd1: b = rsp[15:8];
          2'd2: b = rsp[23:16];
          default: b = rsp[31:24];
        endcase
        h = o[1] ? rsp[31:16] : rsp[15:0];
        if (f3[1:0] == 2'b00)      model_rdata = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
        else if (f3[1:0] == 2'b01) model_rdata = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
        else                       model_rdata = rsp;
      end
    end
    e.rdata     = model_rdata;
    e.stall_cyc = e.mis ? 8'd1 : no_resp ? 8'(2 + rdly + TO) : 8'(3 + rdly + rlat);
    e.valid_cyc = e.mis ? 8'd0 : 8'(rdly + 1);
    sb.push_back(e);

    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; funct3 = f3;
    stall_cnt = 0; nvalid = 0; req_cyc = 0; wait_cyc = 0; in_wait = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      bus_resp_valid = 1'b0; bus_req_ready = 1'b0;
      if (!stall) begin
        done = 1;
        got = sb.pop_front();
        if (!keep) begin mem_read = 0; mem_write = 0; end
        tests++; if (rdata !== got.rdata) begin fails++; $display("FAIL %s rdata got %h want %h", name, rdata, got.rdata); end
        tests++; if (misalign !== got.mis) begin fails++; $display("FAIL %s misalign got %b want %b", name, misalign, got.mis); end
        tests++; if (bus_err !== got.err) begin fails++; $display("FAIL %s bus_err got %b want %b", name, bus_err, got.err); end
        tests++; if (8'(stall_cnt) !== got.stall_cyc) begin fails++; $display("FAIL %s stall_cycles got %0d want %0d", name, stall_cnt, got.stall_cyc); end
        tests++; if (8'(nvalid) !== got.valid_cyc) begin fails++; $display("FAIL %s valid_cycles got %0d want %0d", name, nvalid, got.valid_cyc); end
      end else begin
        stall_cnt++;
        if (bus_req_valid) begin
          nvalid++;
          tests++; if ({bus_req_we, bus_req_addr, bus_req_be, bus_req_wdata} !== {e.we, e.baddr, e.be, e.bwdata}) begin
            fails++; $display("FAIL %s req_fields got we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                              name, bus_req_we, bus_req_addr, bus_req_be, bus_req_wdata, e.we, e.baddr, e.be, e.bwdata);
          end
          bus_req_ready = (req_cyc >= rdly);
          if (bus_req_ready) in_wait = 1;
          req_cyc++;
        end else if (in_wait) begin
          if (!no_resp && wait_cyc == rlat) begin bus_resp_valid = 1'b1; bus_resp_data = rsp; end
          wait_cyc++;
        end
        @(negedge clk);
      end
    end
    if (!done) begin
      fails++; tests++; $display("FAIL %s completion got none within bound want DONE", name);
      mem_read = 0; mem_write = 0; void'(sb.pop_front());
    end else if (!keep) begin
      @(negedge clk); #1;
      tests++; if ({misalign, bus_err} !== 2'b00) begin fails++; $display("FAIL %s pulse_width got %b want 00", name, {misalign, bus_err}); end
    end
  endtask

  task automatic test_loads();
    run_txn("lw_0x100", 1, 0, 32'h100, 32'h0, 3'b010, 0, 0, 32'hDEADBEEF, 0, 0);
    run_txn("lb_0x103", 1, 0, 32'h103, 32'h0, 3'b000, 0, 0, 32'h80112233, 0, 0);
    run_txn("lbu_0x103", 1, 0, 32'h103, 32'h0, 3'b100, 0, 0, 32'h80112233, 0, 0);
    run_txn("lh_late", 1, 0, 32'h106, 32'h0, 3'b001, 2, 2, 32'hC0DE0001, 0, 0);
  endtask

  task automatic test_store_half();
    run_txn("sh_0x202", 0, 1, 32'h202, 32'h0000ABCD, 3'b001, 3, 0, 32'h0, 0, 0);
    run_txn("sb_0x201", 0, 1, 32'h201, 32'h000000A5, 3'b000, 0, 1, 32'h0, 0, 0);
  endtask

  task automatic test_misalign();
    run_txn("lw_0x101", 1, 0, 32'h101, 32'h0, 3'b010, 0, 0, 32'hFFFFFFFF, 0, 0);
    run_txn("rw_both", 1, 1, 32'h104, 32'h11223344, 3'b010, 0, 0, 32'h0, 0, 0);
    run_txn("sh_0x203", 0, 1, 32'h203, 32'h00001234, 3'b001, 0, 0, 32'h0, 0, 0);
    run_txn("size11_0x102", 1, 0, 32'h102, 32'h0, 3'b011, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_spurious_resp();
    @(negedge clk); #1;
    bus_resp_valid = 1'b1; bus_resp_data = 32'h12345678;
    @(negedge clk); #1;
    bus_resp_valid = 1'b0;
    tests++; if (rdata !== model_rdata) begin fails++; $display("FAIL spurious_resp rdata got %h want %h", rdata, model_rdata); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL spurious_resp stall got %b want 0", stall); end
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_lh", 1, 0, 32'h102, 32'h0, 3'b001, 0, 0, 32'h80010000, 0, 1);
    run_txn("b2b_lhu", 1, 0, 32'h100, 32'h0, 3'b101, 0, 0, 32'h1234ABCD, 0, 0);
  endtask

  task automatic test_timeout();
    run_txn("lw_timeout", 1, 0, 32'h300, 32'h0, 3'b010, 0, 0, 32'h0, 1, 0);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    mem_read = 1; addr = 32'h400; funct3 = 3'b010;
    @(negedge clk); #1;
    bus_req_ready = 1'b1;
    @(negedge clk); #1;
    bus_req_ready = 1'b0;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rst_wait pre_stall got %b want 1", stall); end
    #2 rst_n = 1'b0;
    #1;
    model_rdata = 32'h0;
    tests++; if ({stall, bus_req_valid, misalign, bus_err, bus_req_we} !== 5'b0) begin
      fails++; $display("FAIL rst_wait ctrl got %b want 00000", {stall, bus_req_valid, misalign, bus_err, bus_req_we});
    end
    tests++; if ({rdata, bus_req_addr, bus_req_wdata, bus_req_be} !== 100'h0) begin
      fails++; $display("FAIL rst_wait data got rd=%h addr=%h wd=%h be=%h want 0", rdata, bus_req_addr, bus_req_wdata, bus_req_be);
    end
    mem_read = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("lbu_after_rst", 1, 0, 32'h101, 32'h0, 3'b100, 0, 0, 32'h0000FF00, 0, 0);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_half();
    test_misalign();
    test_spurious_resp();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
